// File: rtl/vec_dmem.sv
// vec_dmem: scalar/vector data memory for the vector datapath.
//
// Accepts one request per cycle over a valid/ready handshake. A request
// touches one word (scalar) or LANES consecutive words (vector). Writes
// carry a per-lane mask. Read data is registered and appears one cycle
// after acceptance. An access that would run past DEPTH-1 is refused: it
// modifies nothing and answers rsp_err=1. After reset a clear engine
// writes zero to every word, one word per cycle, before requests are
// accepted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we, req_vec     write/read select, vector/scalar select
//   req_addr            base word address
//   req_wdata, req_mask write data (lane i at bits [i*W +: W]) and lane enables
//   rsp_valid           one-cycle pulse per accepted request
//   rsp_rdata, rsp_err  read data and range error (held while rsp_valid=0)
//   busy                clear engine active
//
// Storage is split into LANES banks; word a lives in bank a % LANES at row
// a / LANES. LANES consecutive words always fall in LANES distinct banks,
// so a vector access is one single-port access per bank.
module vec_dmem #(
  parameter int W     = 32,
  parameter int LANES = 6,
  parameter int DEPTH = 30015,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic               req_vec,
  input  logic [AW-1:0]      req_addr,
  input  logic [LANES*W-1:0] req_wdata,
  input  logic [LANES-1:0]   req_mask,
  output logic               rsp_valid,
  output logic [LANES*W-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               busy
);

  localparam int ROWS = (DEPTH + LANES - 1) / LANES;
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   clr_ptr_q, clr_ptr_d;
  // clr_ptr split into bank/row, tracked incrementally to avoid a divider
  logic [LW-1:0]   clr_bank_q, clr_bank_d;
  logic [RW-1:0]   clr_row_q, clr_row_d;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_CLEAR;
      clr_ptr_q  <= '0;
      clr_bank_q <= '0;
      clr_row_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_bank_q <= clr_bank_d;
      clr_row_q  <= clr_row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_bank_d = clr_bank_q;
    clr_row_d  = clr_row_q;
    busy       = 1'b0;
    req_ready  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy = 1'b1;
        if (clr_ptr_q == PW'(DEPTH - 1)) begin
          state_d    = S_IDLE;
          clr_ptr_d  = '0;
          clr_bank_d = '0;
          clr_row_d  = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + PW'(1);
          if (clr_bank_q == LW'(LANES - 1)) begin
            clr_bank_d = '0;
            clr_row_d  = clr_row_q + RW'(1);
          end else begin
            clr_bank_d = clr_bank_q + LW'(1);
          end
        end
      end
      default: begin
        req_ready = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------ request decode
  logic          clearing;
  logic          accept;
  logic [AW:0]   span_m1;
  logic [AW:0]   last_addr;
  logic          req_err;
  logic [LW-1:0] base_off;
  logic [RW-1:0] base_row;
  logic          bank_re;

  assign clearing  = (state_q == S_CLEAR);
  assign accept    = req_valid && req_ready;
  // One extra bit so an access near the top of the address space cannot wrap.
  assign span_m1   = req_vec ? (AW+1)'(LANES - 1) : '0;
  assign last_addr = {1'b0, req_addr} + span_m1;
  assign req_err   = (last_addr >= (AW+1)'(DEPTH));
  assign base_off  = LW'(req_addr % AW'(LANES));
  assign base_row  = RW'(req_addr / AW'(LANES));
  assign bank_re   = accept && !rst && !req_we && !req_err;

  logic [LANES-1:0][LW-1:0] bank_lane;
  logic [LANES-1:0][RW-1:0] bank_addr;
  logic [LANES-1:0]         bank_we;
  logic [LANES-1:0][W-1:0]  bank_wdata;
  logic [LANES-1:0][W-1:0]  bank_rd;
  logic                     lane_in_span;

  // For each bank: which request lane maps onto it, and at which row.
  // Banks below the base offset hold the wrapped-around tail lanes, which
  // sit one row further on.
  always_comb begin
    bank_lane    = '0;
    bank_addr    = '0;
    bank_we      = '0;
    bank_wdata   = '0;
    lane_in_span = 1'b0;
    for (int b = 0; b < LANES; b++) begin
      if (LW'(b) >= base_off) begin
        bank_lane[b] = LW'(b) - base_off;
        bank_addr[b] = base_row;
      end else begin
        bank_lane[b] = LW'(b + LANES) - base_off;
        bank_addr[b] = base_row + RW'(1);
      end
      lane_in_span  = req_vec || (bank_lane[b] == '0);
      bank_we[b]    = accept && !rst && req_we && !req_err && lane_in_span
                      && req_mask[bank_lane[b]];
      bank_wdata[b] = req_wdata[bank_lane[b]*W +: W];
      if (clearing) begin
        bank_addr[b]  = clr_row_q;
        bank_we[b]    = (clr_bank_q == LW'(b));
        bank_wdata[b] = '0;
      end
    end
  end

  // ---------------------------------------------------------------- banks
  for (genvar gi = 0; gi < LANES; gi++) begin : g_bank
    logic [W-1:0] mem [ROWS];
    logic [W-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (bank_we[gi]) mem[bank_addr[gi]] <= bank_wdata[gi];
      if (bank_re)     rd_q <= mem[bank_addr[gi]];
    end

    assign bank_rd[gi] = rd_q;
  end

  // ------------------------------------------------------------- response
  // Bank read registers only change on an accepted read, so with the lane
  // keep mask and offset captured alongside them the output holds between
  // responses. A cleared keep mask forces zero for writes, errors and
  // lanes beyond a scalar span.
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [LANES-1:0] rsp_keep_q;
  logic [LW-1:0]    rsp_off_q;
  logic [LW:0]      rd_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_keep_q  <= '0;
      rsp_off_q   <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q <= req_err;
        rsp_off_q <= base_off;
        if (req_we || req_err) rsp_keep_q <= '0;
        else if (req_vec)      rsp_keep_q <= '1;
        else                   rsp_keep_q <= LANES'(1);
      end
    end
  end

  always_comb begin
    rsp_rdata = '0;
    rd_sel    = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_sel = {1'b0, rsp_off_q} + (LW+1)'(i);
      if (rd_sel >= (LW+1)'(LANES)) rd_sel = rd_sel - (LW+1)'(LANES);
      if (rsp_keep_q[i]) rsp_rdata[i*W +: W] = bank_rd[rd_sel[LW-1:0]];
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_vec_dmem.sv
// Directed bench for vec_dmem. Two instances share the request bus: a
// DEPTH=16 copy for reset/clear timing and a default DEPTH=30015 copy for
// data and range-boundary checks. Inputs change 1ns after a rising edge;
// outputs are sampled at the same point, i.e. after the edge that
// registered them.
module tb_vec_dmem;

  localparam int W  = 32;
  localparam int L  = 6;
  localparam int DW = W * L;

  logic          clk;
  logic          rst_s, rst_b;
  logic          req_valid, req_we, req_vec;
  logic [31:0]   req_addr;
  logic [DW-1:0] req_wdata;
  logic [L-1:0]  req_mask;

  logic          ready_s, valid_s, err_s, busy_s;
  logic [DW-1:0] rdata_s;
  logic          ready_b, valid_b, err_b, busy_b;
  logic [DW-1:0] rdata_b;

  int checks   = 0;
  int failures = 0;
  int n;

  localparam logic [DW-1:0] D1 = 192'h00000066_00000055_00000044_00000033_00000022_00000011;
  localparam logic [DW-1:0] A6 = 192'h0000000A_0000000A_0000000A_0000000A_0000000A_0000000A;
  localparam logic [DW-1:0] B6 = 192'h0000000B_0000000B_0000000B_0000000B_0000000B_0000000B;
  localparam logic [DW-1:0] AB = 192'h0000000A_0000000B_0000000A_0000000B_0000000A_0000000B;
  localparam logic [DW-1:0] D2 = 192'h00000606_00000505_00000404_00000303_00000202_00000101;
  localparam logic [DW-1:0] X6 = 192'h0000DEAD_0000DEAD_0000DEAD_0000DEAD_0000DEAD_0000DEAD;

  vec_dmem #(.W(W), .LANES(L), .DEPTH(16), .AW(32)) dut_s (
    .clk(clk), .rst(rst_s),
    .req_valid(req_valid), .req_ready(ready_s), .req_we(req_we),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_mask(req_mask),
    .rsp_valid(valid_s), .rsp_rdata(rdata_s), .rsp_err(err_s), .busy(busy_s)
  );

  vec_dmem #(.W(W), .LANES(L), .DEPTH(30015), .AW(32)) dut_b (
    .clk(clk), .rst(rst_b),
    .req_valid(req_valid), .req_ready(ready_b), .req_we(req_we),
    .req_vec(req_vec), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_mask(req_mask),
    .rsp_valid(valid_b), .rsp_rdata(rdata_b), .rsp_err(err_b), .busy(busy_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for one edge; return 1ns after that edge with the
  // response registers visible.
  task automatic issue(input logic we, input logic vec, input logic [31:0] addr,
                       input logic [DW-1:0] wd, input logic [L-1:0] mask);
    req_valid = 1'b1;
    req_we    = we;
    req_vec   = vec;
    req_addr  = addr;
    req_wdata = wd;
    req_mask  = mask;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("txn we=%0d vec=%0d addr=%0d mask=%b | big v=%0d e=%0d d=%h | small v=%0d e=%0d d=%h",
             we, vec, addr, mask, valid_b, err_b, rdata_b, valid_s, err_s, rdata_s);
  endtask

  initial begin
    rst_s = 1'b1; rst_b = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_vec = 1'b0;
    req_addr = '0; req_wdata = '0; req_mask = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", ready_s, 1'b0);
    check1("rst_busy", busy_s, 1'b1);
    check1("rst_valid", valid_s, 1'b0);
    check1("rst_err", err_s, 1'b0);
    checkw("rst_rdata", rdata_s, '0);
    check1("rst_busy_big", busy_b, 1'b1);
    rst_s = 1'b0; rst_b = 1'b0;

    // Clear of DEPTH=16 occupies exactly 16 edges
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      check1("clear_busy", busy_s, 1'b1);
      check1("clear_not_ready", ready_s, 1'b0);
    end
    @(posedge clk); #1;
    check1("clear_done_busy", busy_s, 1'b0);
    check1("clear_done_ready", ready_s, 1'b1);

    // Big instance finishes 30015-16 edges later
    n = 0;
    while (!ready_b && n < 40000) begin
      @(posedge clk); #1;
      n++;
    end
    checkw("big_clear_len", DW'(n), DW'(29999));

    // Vector read at 0 after clear
    issue(1'b0, 1'b1, 32'd0, '0, '0);
    check1("rd0_valid", valid_s, 1'b1);
    check1("rd0_err", err_s, 1'b0);
    checkw("rd0_data", rdata_s, '0);
    checkw("rd0_data_big", rdata_b, '0);
    @(posedge clk); #1;
    check1("idle_no_valid", valid_b, 1'b0);

    // Vector round trip at 100
    issue(1'b1, 1'b1, 32'd100, D1, 6'b111111);
    check1("wr100_valid", valid_b, 1'b1);
    check1("wr100_err", err_b, 1'b0);
    checkw("wr100_rdata", rdata_b, '0);
    issue(1'b0, 1'b1, 32'd100, '0, '0);
    check1("rd100_valid", valid_b, 1'b1);
    checkw("rd100_data", rdata_b, D1);
    @(posedge clk); #1;
    check1("hold_valid", valid_b, 1'b0);
    checkw("hold_data", rdata_b, D1);

    // Masked write at 200
    issue(1'b1, 1'b1, 32'd200, A6, 6'b111111);
    issue(1'b1, 1'b1, 32'd200, B6, 6'b010101);
    issue(1'b0, 1'b1, 32'd200, '0, '0);
    checkw("mask_rd", rdata_b, AB);
    issue(1'b0, 1'b0, 32'd201, '0, '0);
    checkw("scalar_rd201", rdata_b, 192'h0A);
    check1("scalar_rd201_err", err_b, 1'b0);

    // Scalar write stores lane 0 only
    issue(1'b1, 1'b0, 32'd50, D1, 6'b111111);
    issue(1'b0, 1'b1, 32'd50, '0, '0);
    checkw("scalar_wr50", rdata_b, 192'h11);

    // Range boundary
    issue(1'b1, 1'b1, 32'd30009, D2, 6'b111111);
    check1("wr30009_err", err_b, 1'b0);
    issue(1'b0, 1'b1, 32'd30009, '0, '0);
    checkw("rd30009", rdata_b, D2);
    check1("rd30009_err", err_b, 1'b0);
    issue(1'b1, 1'b1, 32'd30010, X6, 6'b111111);
    check1("wr30010_valid", valid_b, 1'b1);
    check1("wr30010_err", err_b, 1'b1);
    checkw("wr30010_rdata", rdata_b, '0);
    issue(1'b0, 1'b0, 32'd30010, '0, '0);
    check1("rd30010_err", err_b, 1'b0);
    checkw("rd30010_unchanged", rdata_b, 192'h202);
    issue(1'b0, 1'b0, 32'hFFFF_FFFF, '0, '0);
    check1("rd_ffff_err", err_b, 1'b1);
    checkw("rd_ffff_data", rdata_b, '0);
    issue(1'b0, 1'b0, 32'd30014, '0, '0);
    check1("rd30014_err", err_b, 1'b0);
    checkw("rd30014_data", rdata_b, 192'h606);
    issue(1'b0, 1'b0, 32'd30015, '0, '0);
    check1("rd30015_err", err_b, 1'b1);
    issue(1'b0, 1'b1, 32'd0, '0, '0);
    checkw("word0_nowrap", rdata_b, '0);

    // Reset mid-operation on the DEPTH=16 instance
    issue(1'b1, 1'b1, 32'd4, D1, 6'b111111);
    check1("s_wr4_err", err_s, 1'b0);
    issue(1'b0, 1'b1, 32'd4, '0, '0);
    checkw("s_rd4", rdata_s, D1);
    req_valid = 1'b1; req_we = 1'b0; req_vec = 1'b1; req_addr = 32'd4;
    rst_s = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_s = 1'b0;
    check1("rst_mid_valid", valid_s, 1'b0);
    check1("rst_mid_busy", busy_s, 1'b1);
    check1("rst_mid_ready", ready_s, 1'b0);
    n = 0;
    while (!ready_s && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkw("reclear_len", DW'(n), DW'(16));
    issue(1'b0, 1'b1, 32'd4, '0, '0);
    check1("s_rd4_after_valid", valid_s, 1'b1);
    checkw("s_rd4_after", rdata_s, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
